alarm_setting_datapath: RTL

//   Command-consuming end of the alarm control path. Receives the single-cycle ALM_ONOFF/ALM_HOUR/ALM_MIN command

---
 rtl/alarm_setting_datapath.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/alarm_setting_datapath.sv
// alarm_setting_datapath: holds the alarm time and enable state, and
// compares the alarm time against the running clock. Sequences the
// ringing/buzzer outputs in response to the alarm control FSM's
// ALM_ONOFF/ALM_HOUR/ALM_MIN command pulses.
// Optional feature: define ALARM_SNOOZE_EN to add the SNOOZING state and
// its snooze target registers. Without it, the snooze port is ignored.
module alarm_setting_datapath #(
  parameter int unsigned RESET_HOUR   = 7,
  parameter int unsigned RESET_MIN    = 0,
  parameter int unsigned RING_SECONDS = 60,
  parameter int unsigned SNOOZE_MIN   = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       alm_onoff,
  input  logic       alm_hour,
  input  logic       alm_min,
  input  logic       tick_1hz,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  input  logic       dismiss,
  input  logic       snooze,
  output logic       alarm_en,
  output logic [4:0] alarm_hour,
  output logic [5:0] alarm_min,
  output logic       ringing,
  output logic       buzzer
);

  localparam logic [4:0] HOUR_INIT  = 5'(RESET_HOUR);
  localparam logic [5:0] MIN_INIT   = 6'(RESET_MIN);
  localparam logic [8:0] RING_LIMIT = 9'(RING_SECONDS);

`ifdef ALARM_SNOOZE_EN
  typedef enum logic [1:0] {S_IDLE, S_RINGING, S_SNOOZING} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RINGING} state_t;
`endif

  state_t     state, state_nxt;
  logic       fired, fired_nxt;
  logic [7:0] ring_cnt, ring_cnt_nxt;
  logic       beep, beep_nxt;
  logic       en_nxt;
  logic [4:0] hour_nxt;
  logic [5:0] min_nxt;
  logic       ringing_nxt;
  logic       buzzer_nxt;
  logic       match;
  logic       ring_expire;

`ifdef ALARM_SNOOZE_EN
  localparam logic [5:0] SNZ_ADD  = 6'(SNOOZE_MIN);
  localparam logic [5:0] SNZ_WRAP = 6'(60 - SNOOZE_MIN);

  logic [4:0] snz_hour, snz_hour_nxt;
  logic [5:0] snz_min, snz_min_nxt;
  logic [4:0] tgt_hour;
  logic [5:0] tgt_min;
  logic       snz_due;
`else
  logic unused_snooze;
  assign unused_snooze = snooze & (SNOOZE_MIN != 0);
`endif

  // Alarm time edits and enable toggle; accepted in every state.
  always_comb begin
    en_nxt   = alarm_en;
    hour_nxt = alarm_hour;
    min_nxt  = alarm_min;
    if (alm_onoff) begin
      en_nxt = ~alarm_en;
    end
    if (alm_hour) begin
      hour_nxt = (alarm_hour == 5'd23) ? '0 : alarm_hour + 5'd1;
    end
    if (alm_min) begin
      min_nxt = (alarm_min == 6'd59) ? '0 : alarm_min + 6'd1;
    end
  end

  // Time match detection with one trigger per matching minute.
  always_comb begin
    match = alarm_en && (cur_hour == alarm_hour) && (cur_min == alarm_min) &&
            (cur_sec == 6'd0) && !fired;
    fired_nxt = fired;
    if (match) begin
      fired_nxt = 1'b1;
    end else if (cur_min != alarm_min) begin
      fired_nxt = 1'b0;
    end
  end

  // Ring length expiry: the tick that brings the count to RING_SECONDS.
  always_comb begin
    ring_expire = tick_1hz && (({1'b0, ring_cnt} + 9'd1) >= RING_LIMIT);
  end

`ifdef ALARM_SNOOZE_EN
  // Snooze target = current time + SNOOZE_MIN. The carry test is done as
  // cur_min >= 60-SNOOZE_MIN so both branches stay 6 bits wide.
  always_comb begin
    if (cur_min >= SNZ_WRAP) begin
      tgt_min  = cur_min - SNZ_WRAP;
      tgt_hour = (cur_hour >= 5'd23) ? '0 : cur_hour + 5'd1;
    end else begin
      tgt_min  = cur_min + SNZ_ADD;
      tgt_hour = cur_hour;
    end
    snz_due = (cur_hour == snz_hour) && (cur_min == snz_min) && (cur_sec == 6'd0);
  end
`endif

  // Ring FSM next state, ring counter and beep phase.
  always_comb begin
    state_nxt    = state;
    ring_cnt_nxt = ring_cnt;
    beep_nxt     = beep;
`ifdef ALARM_SNOOZE_EN
    snz_hour_nxt = snz_hour;
    snz_min_nxt  = snz_min;
`endif
    case (state)
      S_IDLE: begin
        if (match) begin
          state_nxt    = S_RINGING;
          ring_cnt_nxt = '0;
          beep_nxt     = 1'b1;
        end
      end
      S_RINGING: begin
        if (alm_onoff || dismiss) begin
          state_nxt = S_IDLE;
`ifdef ALARM_SNOOZE_EN
        end else if (snooze) begin
          state_nxt    = S_SNOOZING;
          snz_hour_nxt = tgt_hour;
          snz_min_nxt  = tgt_min;
`endif
        end else if (ring_expire) begin
          state_nxt = S_IDLE;
        end else if (tick_1hz) begin
          ring_cnt_nxt = ring_cnt + 8'd1;
          beep_nxt     = ~beep;
        end
      end
`ifdef ALARM_SNOOZE_EN
      S_SNOOZING: begin
        if (alm_onoff || dismiss) begin
          state_nxt = S_IDLE;
        end else if (snz_due) begin
          state_nxt    = S_RINGING;
          ring_cnt_nxt = '0;
          beep_nxt     = 1'b1;
        end
      end
`endif
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    ringing_nxt = (state_nxt == S_RINGING);
    buzzer_nxt  = ringing_nxt & beep_nxt;
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      fired      <= 1'b0;
      ring_cnt   <= '0;
      beep       <= 1'b0;
      alarm_en   <= 1'b0;
      alarm_hour <= HOUR_INIT;
      alarm_min  <= MIN_INIT;
      ringing    <= 1'b0;
      buzzer     <= 1'b0;
    end else begin
      state      <= state_nxt;
      fired      <= fired_nxt;
      ring_cnt   <= ring_cnt_nxt;
      beep       <= beep_nxt;
      alarm_en   <= en_nxt;
      alarm_hour <= hour_nxt;
      alarm_min  <= min_nxt;
      ringing    <= ringing_nxt;
      buzzer     <= buzzer_nxt;
    end
  end

`ifdef ALARM_SNOOZE_EN
  // Snooze target registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      snz_hour <= '0;
      snz_min  <= '0;
    end else begin
      snz_hour <= snz_hour_nxt;
      snz_min  <= snz_min_nxt;
    end
  end
`endif

endmodule
